fetch_queue: RTL

- Parametrised instruction fetch buffer between the ibus and the decode stage.
- Replaces the single-entry pc/instruction save register with a DEPTH-entry FIFO of {pc, instr} pairs.
- Owns the fetch PC, holds the ibus request stable until data_ok, and handles branch redirects while a request is in flight.
- Decode pops entries with a valid/ready handshake, where ready is ~stallD.

---
 rtl/fetch_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch buffer: owns the fetch PC, drives the ibus and queues {pc, instr} pairs for decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
   parameter int              DEPTH    = 4,
   parameter int              ADDR_W   = 64,
   parameter int              INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      ireq_valid,
   output logic [ADDR_W-1:0]         ireq_addr,
   input  logic                      iresp_data_ok,
   input  logic [INSTR_W-1:0]        iresp_data,
   input  logic                      redirect_valid,
   input  logic [ADDR_W-1:0]         redirect_pc,
   output logic                      out_valid,
   output logic [ADDR_W-1:0]         out_pc,
   output logic [INSTR_W-1:0]        out_instr,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    out_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   fetch_pc, fetch_pc_n;
   logic [ADDR_W-1:0]   req_addr, req_addr_n;
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    count, count_n;
   logic [ADDR_W-1:0]   pc_mem    [DEPTH];
   logic [INSTR_W-1:0]  instr_mem [DEPTH];
   logic                has_head, accept, push, pop, bypass_take;
`ifdef FETCH_QUEUE_BYPASS_EN
   logic                bypass;
`endif

   always_comb begin
      has_head = (count != '0);
      accept   = (state == REQ) && iresp_data_ok && !redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass      = accept && !has_head && reset;
      bypass_take = bypass && out_ready;
`else
      bypass_take = 1'b0;
`endif
      push = accept && !bypass_take;
      pop  = has_head && out_ready && !redirect_valid;

      count_n    = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
      fetch_pc_n = redirect_valid ? redirect_pc :
                   accept         ? fetch_pc + ADDR_W'(4) : fetch_pc;

      state_n = state;
      case (state)
         REQ: begin
            if (redirect_valid)     state_n = iresp_data_ok ? REQ : DROP;
            else if (iresp_data_ok) state_n = (count_n == FULL) ? IDLE : REQ;
         end
         DROP: begin
            if (iresp_data_ok)      state_n = REQ;
         end
         IDLE: begin
            if (redirect_valid || count_n != FULL) state_n = REQ;
         end
         default:                   state_n = REQ;
      endcase

      // The bus address must not move while a request is unanswered, even if fetch_pc was redirected.
      req_addr_n = (state != IDLE && !iresp_data_ok) ? req_addr : fetch_pc_n;
   end

   always_comb begin
      ireq_valid = reset && (state != IDLE);
      ireq_addr  = ireq_valid ? req_addr : '0;
      out_count  = count;
      out_valid  = has_head;
      out_pc     = has_head ? pc_mem[rd_ptr]    : '0;
      out_instr  = has_head ? instr_mem[rd_ptr] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (bypass) begin
         out_valid = 1'b1;
         out_pc    = fetch_pc;
         out_instr = iresp_data;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= REQ;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         req_addr <= req_addr_n;
         count    <= count_n;
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Storage needs no reset: an entry is only visible once count covers it.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= fetch_pc;
         instr_mem[wr_ptr] <= iresp_data;
      end
   end

endmodule
